// File: rtl/dom_sched_pkg.sv
// rtl/dom_sched_pkg.sv - shared constants and helpers for the masked GF(4) multiplier scheduler
package dom_sched_pkg;

    localparam int LFSR_W = 32;
    // Galois right-shift toggle mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h8020_0003;
    localparam int MAX_REQ = 8;

    function automatic int zwidth(input int shares);
        return 2 * shares * (shares - 1);
    endfunction

    // Returns {found, index} of the first set bit at or above ptr, wrapping at n
    function automatic logic [3:0] rr_first(input logic [MAX_REQ-1:0] req,
                                            input logic [2:0] ptr,
                                            input int n);
        logic [3:0] res;
        int idx;
        res = '0;
        for (int i = n - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % n;
            if (req[idx]) res = {1'b1, idx[2:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/dom_mul_gf4_sched_if.sv
// rtl/dom_mul_gf4_sched_if.sv - requester and multiplier signal bundle for the scheduler
interface dom_mul_gf4_sched_if
    import dom_sched_pkg::*;
#(
    parameter int SHARES = 2,
    parameter int NREQ   = 2
);
    localparam int SW = 4 * SHARES;
    localparam int ZW = zwidth(SHARES);

    logic [NREQ-1:0]    ReqValidxSI;
    logic [NREQ-1:0]    ReqReadyxSO;
    logic [NREQ*SW-1:0] _ReqXxDI;
    logic [NREQ*SW-1:0] _ReqYxDI;
    logic               HoldxSI;
    logic [SW-1:0]      _MulXxDO;
    logic [SW-1:0]      _MulYxDO;
    logic [ZW-1:0]      _MulZxDO;
    logic [SW-1:0]      _MulQxDI;
    logic [NREQ-1:0]    RspValidxSO;
    logic [SW-1:0]      _QxDO;
    logic               IdlexSO;

    modport slave (
        input  ReqValidxSI, _ReqXxDI, _ReqYxDI, HoldxSI, _MulQxDI,
        output ReqReadyxSO, _MulXxDO, _MulYxDO, _MulZxDO, RspValidxSO, _QxDO, IdlexSO
    );

    modport master (
        output ReqValidxSI, _ReqXxDI, _ReqYxDI, HoldxSI, _MulQxDI,
        input  ReqReadyxSO, _MulXxDO, _MulYxDO, _MulZxDO, RspValidxSO, _QxDO, IdlexSO
    );

endinterface

// File: rtl/dom_rand_lfsr.sv
// rtl/dom_rand_lfsr.sv - 32-bit Galois LFSR supplying fresh masking randomness per issue
module dom_rand_lfsr
    import dom_sched_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = 32'h1,
    parameter int                OUT_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             step,
    output logic [OUT_W-1:0] rnd
);

    logic [LFSR_W-1:0] state;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= SEED;
        end else if (step) begin
            state <= {1'b0, state[LFSR_W-1:1]} ^ (state[0] ? LFSR_POLY : '0);
        end
    end

    assign rnd = state[OUT_W-1:0];

endmodule

// File: rtl/dom_mul_gf4_sched.sv
// rtl/dom_mul_gf4_sched.sv - round-robin sharing of one pipelined DOM GF(4) multiplier (SCHED_ZERO_RAND_EN ties Z to 0)
module dom_mul_gf4_sched
    import dom_sched_pkg::*;
#(
    parameter int          SHARES    = 2,
    parameter int          NREQ      = 2,
    parameter int          MUL_LAT   = 1,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input logic                ClkxCI,
    input logic                RstxBI,
    dom_mul_gf4_sched_if.slave bus
);

    localparam int SW = 4 * SHARES;
    localparam int ZW = zwidth(SHARES);

    logic [2:0]         ptr;
    logic [MAX_REQ-1:0] req_ext;
    logic [3:0]         pick;
    logic [2:0]         gidx;
    logic               grant_hit;
    logic [NREQ-1:0]    grant;
    logic [SW-1:0]      mul_x;
    logic [SW-1:0]      mul_y;
    logic [MUL_LAT-1:0] tag_vld;
    logic [NREQ-1:0]    tag_id [MUL_LAT];

    always_comb begin
        req_ext = '0;
        req_ext[NREQ-1:0] = bus.ReqValidxSI;
        pick      = rr_first(req_ext, ptr, NREQ);
        gidx      = pick[2:0];
        grant_hit = pick[3] & ~bus.HoldxSI & RstxBI;
        grant     = grant_hit ? (NREQ'(1) << gidx) : '0;
    end

    // Operands stay zero when nothing issues so the multiplier inputs do not toggle
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (grant[r]) begin
                mul_x = mul_x | bus._ReqXxDI[r*SW +: SW];
                mul_y = mul_y | bus._ReqYxDI[r*SW +: SW];
            end
        end
    end

    always_ff @(posedge ClkxCI) begin
        if (!RstxBI) begin
            ptr <= 3'd0;
        end else if (grant_hit) begin
            ptr <= (gidx == 3'(NREQ - 1)) ? 3'd0 : gidx + 3'd1;
        end
    end

    always_ff @(posedge ClkxCI) begin
        if (!RstxBI) begin
            tag_vld <= '0;
            for (int s = 0; s < MUL_LAT; s++) tag_id[s] <= '0;
        end else begin
            tag_vld[0] <= grant_hit;
            tag_id[0]  <= grant;
            for (int s = 1; s < MUL_LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
    end

    assign bus.ReqReadyxSO = grant;
    assign bus._MulXxDO    = mul_x;
    assign bus._MulYxDO    = mul_y;
    assign bus.RspValidxSO = (RstxBI && tag_vld[MUL_LAT-1]) ? tag_id[MUL_LAT-1] : '0;
    assign bus._QxDO       = bus._MulQxDI;
    assign bus.IdlexSO     = ~RstxBI | ~(|tag_vld);

`ifdef SCHED_ZERO_RAND_EN
    assign bus._MulZxDO = '0;
`else
    localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

    // Advancing only on issue guarantees each Z value feeds exactly one operation
    dom_rand_lfsr #(
        .SEED  (SEED_EFF),
        .OUT_W (ZW)
    ) u_lfsr (
        .clk    (ClkxCI),
        .resetn (RstxBI),
        .step   (grant_hit),
        .rnd    (bus._MulZxDO)
    );
`endif

endmodule

// File: tb/tb_dom_mul_gf4_sched.sv
// tb/tb_dom_mul_gf4_sched.sv - scoreboard bench for dom_mul_gf4_sched with a behavioural multiplier
module tb_dom_mul_gf4_sched;

    localparam logic [31:0] SEED = 32'hACE1_2468;

    typedef struct {
        logic [1:0] id;
        logic [3:0] prod;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] x_op [2];
    logic [7:0] y_op [2];
    logic [31:0] lfsr_m = SEED;
    sb_entry_t  sb [$];
    int         vectors = 0;
    int         miscompares = 0;

    dom_mul_gf4_sched_if #(.SHARES(2), .NREQ(2)) bus ();

    dom_mul_gf4_sched #(
        .SHARES(2), .NREQ(2), .MUL_LAT(1), .LFSR_SEED(SEED)
    ) dut (
        .ClkxCI (clk),
        .RstxBI (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    assign bus._ReqXxDI = {x_op[1], x_op[0]};
    assign bus._ReqYxDI = {y_op[1], y_op[0]};

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r, aa;
        r  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa[3] ? ((aa << 1) ^ 4'h3) : (aa << 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Behavioural one-stage multiplier: product re-masked with Z across the two shares
    always @(posedge clk) begin
        bus._MulQxDI <= {bus._MulZxDO,
                         gf_mul(bus._MulXxDO[3:0] ^ bus._MulXxDO[7:4],
                                bus._MulYxDO[3:0] ^ bus._MulYxDO[7:4]) ^ bus._MulZxDO};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [1:0] exp_grant);
        sb_entry_t  e;
        int         idx;
        logic [3:0] exp_z;
        @(negedge clk);
        chk("idle", bus.IdlexSO, (sb.size() == 0));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_id", bus.RspValidxSO, e.id);
            chk("rsp_q", bus._QxDO[3:0] ^ bus._QxDO[7:4], e.prod);
        end else begin
            chk("rsp_none", bus.RspValidxSO, 0);
        end
        chk("grant", bus.ReqReadyxSO, exp_grant);
        idx = exp_grant[1] ? 1 : 0;
        if (exp_grant != 2'b00) begin
            chk("mul_x", bus._MulXxDO, x_op[idx]);
            chk("mul_y", bus._MulYxDO, y_op[idx]);
        end else begin
            chk("mul_x_idle", bus._MulXxDO, 0);
            chk("mul_y_idle", bus._MulYxDO, 0);
        end
`ifdef SCHED_ZERO_RAND_EN
        exp_z = 4'h0;
`else
        exp_z = lfsr_m[3:0];
`endif
        chk("mul_z", bus._MulZxDO, exp_z);
        if (exp_grant != 2'b00) begin
            sb.push_back('{exp_grant,
                           gf_mul(x_op[idx][3:0] ^ x_op[idx][7:4], y_op[idx][3:0] ^ y_op[idx][7:4])});
            lfsr_m = lfsr_next(lfsr_m);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.ReqValidxSI = 2'b00;
        sb.delete();
        tick(2'b00);
        lfsr_m = SEED;
        tick(2'b00);
        rstn = 1'b1;
    endtask

    initial begin
        logic [3:0] m1, m2;
        logic [1:0] g;
        bus.ReqValidxSI = 2'b00;
        bus.HoldxSI     = 1'b0;
        x_op[0] = 8'h00; x_op[1] = 8'h00;
        y_op[0] = 8'h00; y_op[1] = 8'h00;
        do_reset();

        // single requester, X=0 times Y=B
        x_op[0] = 8'h00;
        y_op[0] = 8'h0B;
        bus.ReqValidxSI = 2'b01;
        tick(2'b01);
        bus.ReqValidxSI = 2'b00;
        tick(2'b00);

        // both requesters contend every cycle
        do_reset();
        bus.ReqValidxSI = 2'b11;
        for (int i = 0; i < 8; i++) begin
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick(g);
            x_op[g[1]] = 8'($urandom);
            y_op[g[1]] = 8'($urandom);
        end

        // hold with an operation still in flight, then release
        bus.HoldxSI = 1'b1;
        tick(2'b00);
        tick(2'b00);
        tick(2'b00);
        bus.HoldxSI = 1'b0;
        tick(2'b01);
        tick(2'b10);
        bus.ReqValidxSI = 2'b00;
        tick(2'b00);

        // four back-to-back issues, twice from the same seed
        for (int k = 0; k < 2; k++) begin
            do_reset();
            bus.ReqValidxSI = 2'b01;
            for (int i = 0; i < 4; i++) begin
                x_op[0] = 8'($urandom);
                y_op[0] = 8'($urandom);
                tick(2'b01);
            end
            bus.ReqValidxSI = 2'b00;
            tick(2'b00);
        end

        // exhaustive operand sweep through requester 1 with random share masks
        bus.ReqValidxSI = 2'b10;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                m1 = 4'($urandom_range(0, 15));
                m2 = 4'($urandom_range(0, 15));
                x_op[1] = {m1, 4'(a) ^ m1};
                y_op[1] = {m2, 4'(b) ^ m2};
                tick(2'b10);
            end
        end
        bus.ReqValidxSI = 2'b00;
        tick(2'b00);

        // reset right after an issue drops the response and clears the pointer
        x_op[0] = 8'h5A;
        y_op[0] = 8'h3C;
        bus.ReqValidxSI = 2'b01;
        tick(2'b01);
        do_reset();
        bus.ReqValidxSI = 2'b11;
        tick(2'b01);
        bus.ReqValidxSI = 2'b00;
        tick(2'b00);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dom_mul_gf4_sched.md
Name: dom_mul_gf4_sched

Overview:
- Round-robin scheduler that shares one pipelined masked GF(4) multiplier (shared_mul_gf4, DOM, SHARES shares) between NREQ requesters.
- Muxes the granted requester's shared operands onto the multiplier and supplies fresh randomness Z from an internal LFSR on every issue.
- Tracks in-flight operations with a tag pipeline and returns each result to its originating requester with a one-hot response strobe.
- Sits between the masked S-box stage controllers and a single multiplier instance.

Parameters:
- SHARES, 2, number of masking shares.
- NREQ, 2, number of requesters (2..8).
- MUL_LAT, 1, multiplier latency in cycles (1 when the multiplier is built with PIPELINED=1).
- LFSR_SEED, 32'hACE1_2468, LFSR reset value. A value of 0 is replaced by 1.

Ports:
- ClkxCI, in, 1: clock.
- RstxBI, in, 1: reset, synchronous, active-low.
- ReqValidxSI, in, NREQ: per-requester operand valid.
- ReqReadyxSO, out, NREQ: per-requester grant, one-hot or zero.
- _ReqXxDI, in, NREQ*4*SHARES: X operands; requester r occupies slice [r*4*SHARES +: 4*SHARES]; share i bit j at i*4+j.
- _ReqYxDI, in, NREQ*4*SHARES: Y operands, same layout as _ReqXxDI.
- HoldxSI, in, 1: suppresses new grants while high.
- _MulXxDO, out, 4*SHARES: X operand to the multiplier.
- _MulYxDO, out, 4*SHARES: Y operand to the multiplier.
- _MulZxDO, out, 2*SHARES*(SHARES-1): fresh randomness to the multiplier.
- _MulQxDI, in, 4*SHARES: multiplier result.
- RspValidxSO, out, NREQ: one-hot result strobe.
- _QxDO, out, 4*SHARES: result shares, broadcast to all requesters.
- IdlexSO, out, 1: no operation in flight.

Behaviour:
- Clock ClkxCI; reset RstxBI is synchronous, active-low. All state is sampled on the rising edge.
- Reset values:
  - RR pointer = 0; tag pipeline cleared; LFSR = seed.
  - RspValidxSO = 0; IdlexSO = 1; ReqReadyxSO = 0 while reset is asserted.
- Arbitration (combinational):
  - Grant = first r with ReqValidxSI[r]=1, searching from the pointer upward with wrap-around.
  - No grant if HoldxSI=1 or no request is valid.
  - ReqReadyxSO = one-hot grant. The transfer happens in the cycle valid & ready are both high.
  - A requester holds its valid and operands stable until it is granted.
- Pointer update: after a grant to r, the pointer becomes (r+1) mod NREQ. With no grant, the pointer holds.
- Issue cycle t:
  - _MulXxDO and _MulYxDO carry the granted slices.
  - _MulZxDO = the low 2*SHARES*(SHARES-1) bits of the LFSR.
  - The LFSR advances one step at the edge ending cycle t.
- Idle cycles:
  - _MulXxDO and _MulYxDO are all-zero, so the multiplier inputs do not toggle.
  - _MulZxDO is still driven from the LFSR, which does not advance.
  - Z is never reused across two issues.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1. A single-cycle step must supply at least 2*SHARES*(SHARES-1) bits; widen the LFSR via package constant if SHARES exceeds 4.
- Tag pipeline:
  - MUL_LAT stages of {valid, one-hot id}; stage 0 is loaded with the issue.
  - RspValidxSO = last stage when its valid is set, else 0.
  - _QxDO = _MulQxDI passed through combinationally. It is only meaningful while RspValidxSO is nonzero.
- Latency and throughput:
  - A request granted in cycle t gets its response strobe in cycle t+MUL_LAT.
  - Throughput is one issue per cycle, with no backpressure on responses.
- IdlexSO = 1 when no tag stage is valid.
- Reset mid-operation: in-flight tags are dropped, no response is emitted for them, and the LFSR is reseeded.
- Simultaneous requests: one grant per cycle. Losers keep their valid and are served in RR order. Each requester is starved for at most NREQ-1 grants.
- HoldxSI rising with an operation in flight: that operation still completes.

Optional Feature:
- Macro SCHED_ZERO_RAND_EN.
- Defined: _MulZxDO is tied to 0 and the LFSR is not instantiated. This is for functional-only simulation with deterministic unmasked checks.
- Undefined (default): LFSR randomness as specified above.

Decomposition:
- Package dom_sched_pkg holds:
  - LFSR width and polynomial constants.
  - Function zwidth(SHARES) = 2*SHARES*(SHARES-1).
  - Round-robin "first set bit from pointer" function.
- One sub-module, dom_rand_lfsr: seed, step enable, parallel output. The macro removes it.

Test Plan:
- Single requester, SHARES=2, X share0=4'h0, Y=4'hB, share1=0: grant at t, RspValidxSO=2'b01 at t+1, XOR of shares of _QxDO = 4'h0.
- Both valid every cycle for 8 cycles, no hold: grants alternate 01,10,01,...; responses one cycle later in the same order; IdlexSO=0 throughout.
- HoldxSI=1 for 3 cycles with requests pending: ReqReadyxSO=0, _MulXxDO=0, LFSR unchanged; release gives the first grant to the requester at the pointer.
- Issue 4 ops back to back: _MulZxDO is distinct on each issue cycle and repeats after reset with the same seed. With SCHED_ZERO_RAND_EN, _MulZxDO=0 throughout.
- Sweep all 16x16 unmasked operands through requester 1 against a golden GF(4) multiply on the XOR of the shares; every response is tagged RspValidxSO=2'b10.
- Assert RstxBI=0 one cycle after an issue: no RspValidxSO pulse; IdlexSO=1 and the pointer is 0 after reset.
